feedback_blinker: RTL



---
 rtl/feedback_blinker_if.sv | 28 ++
 rtl/feedback_blinker.sv | 120 ++++++++++++
 2 files changed

// File: rtl/feedback_blinker_if.sv
// Request/feedback bundle between the game FSM and the blink stretcher.
// The master side issues blink requests; the slave side drives the LED/buzzer pin.
interface feedback_blinker_if;
   logic       req;
   logic [2:0] n_blinks;
   logic       sig_out;
   logic       busy;
   logic [5:0] pending;
   logic       drop;

   modport master (
      output req,
      output n_blinks,
      input  sig_out,
      input  busy,
      input  pending,
      input  drop
   );

   modport slave (
      input  req,
      input  n_blinks,
      output sig_out,
      output busy,
      output pending,
      output drop
   );
endinterface

// File: rtl/feedback_blinker.sv
// Stretches single-cycle event pulses into trains of visible blinks on one pin.
// Requests are registered first, then accumulated into a saturating pending count.
module feedback_blinker #(
   parameter int unsigned ON_CYCLES  = 16'd25000,
   parameter int unsigned OFF_CYCLES = 16'd25000,
   parameter int unsigned CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   feedback_blinker_if.slave  bus
);

   localparam logic [CNT_W-1:0] OnLast  = CNT_W'(ON_CYCLES);
   localparam logic [CNT_W-1:0] OffLast = CNT_W'(OFF_CYCLES);
   localparam logic [CNT_W-1:0] TimerOne = CNT_W'(1);

   typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [5:0]       pending_q, pending_d;
   logic             sig_q, sig_d;
   logic             drop_q, drop_d;
   logic             req_q;
   logic [2:0]       n_q;

   logic [2:0]       add;
   logic             start;
   logic             have_work;
   logic [6:0]       sum;

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      sig_d     = sig_q;
      start     = 1'b0;
      add       = req_q ? ((n_q == 3'd0) ? 3'd1 : n_q) : 3'd0;
      have_work = (pending_q != 6'd0) || (add != 3'd0);

      unique case (state_q)
         StIdle: begin
            sig_d   = 1'b0;
            timer_d = '0;
            if (have_work) begin
               state_d = StOn;
               sig_d   = 1'b1;
               timer_d = TimerOne;
               start   = 1'b1;
            end
         end
         StOn: begin
            if (timer_q == OnLast) begin
               state_d = StOff;
               sig_d   = 1'b0;
               timer_d = TimerOne;
            end else begin
               timer_d = timer_q + TimerOne;
            end
         end
         StOff: begin
            if (timer_q == OffLast) begin
               // A request landing on the gap's last edge chains straight into ON.
               if (have_work) begin
                  state_d = StOn;
                  sig_d   = 1'b1;
                  timer_d = TimerOne;
                  start   = 1'b1;
               end else begin
                  state_d = StIdle;
                  sig_d   = 1'b0;
                  timer_d = '0;
               end
            end else begin
               timer_d = timer_q + TimerOne;
            end
         end
         default: begin
            state_d = StIdle;
            sig_d   = 1'b0;
            timer_d = '0;
         end
      endcase

      // start only fires when pending or add is non-zero, so this cannot underflow.
      sum = {1'b0, pending_q} + {4'b0, add} - {6'b0, start};
      if (sum > 7'd63) begin
         pending_d = 6'd63;
         drop_d    = 1'b1;
      end else begin
         pending_d = sum[5:0];
         drop_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         timer_q   <= '0;
         pending_q <= 6'd0;
         sig_q     <= 1'b0;
         drop_q    <= 1'b0;
         req_q     <= 1'b0;
         n_q       <= 3'd0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         pending_q <= pending_d;
         sig_q     <= sig_d;
         drop_q    <= drop_d;
         req_q     <= bus.req;
         n_q       <= bus.n_blinks;
      end
   end

   assign bus.sig_out = sig_q;
   assign bus.busy    = (state_q != StIdle);
   assign bus.pending = pending_q;
   assign bus.drop    = drop_q;

endmodule
